// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter: requester IDs and FIFO sizing.
package mem_port_arbiter_pkg;

    typedef enum logic {
        ARB_FETCH = 1'b0,
        ARB_DATA  = 1'b1
    } arbId_e;

    localparam int ARB_MAX_OUTSTANDING_LIMIT = 8;
    localparam int ARB_CNT_W = $clog2(ARB_MAX_OUTSTANDING_LIMIT + 1);

    function automatic arbId_e arb_other(input arbId_e id);
        return (id == ARB_FETCH) ? ARB_DATA : ARB_FETCH;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory handshake signals around mem_port_arbiter.
interface mem_port_arbiter_if;

    logic        f_req_i;
    logic [31:0] f_addr_i;
    logic        f_gnt_o;
    logic        f_rvalid_o;
    logic [31:0] f_rdata_o;

    logic        d_req_i;
    logic [3:0]  d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;

    logic        mem_req_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    logic        err_o;

    // Arbiter view.
    modport master (
        input  f_req_i, f_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output f_gnt_o, f_rvalid_o, f_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
    );

    // Requester/memory environment view.
    modport slave (
        output f_req_i, f_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  f_gnt_o, f_rvalid_o, f_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
    );

endinterface

// File: rtl/mem_port_arbiter_id_fifo.sv
// In-order FIFO of requester IDs for outstanding memory transactions; push+pop when full is allowed.
module arb_id_fifo
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  arbId_e               id_in,
    output arbId_e               id_head,
    output logic                 full,
    output logic                 empty,
    output logic [ARB_CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    arbId_e           slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap modulo DEPTH, so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == ARB_CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign id_head = slots[rd_ptr];

    // NOTE: the ID storage has no reset; only pointers and count define which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= id_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between fetch (F) and data (D); steers in-order responses back by ID.
// Build option: define ARB_ROUND_ROBIN_EN for two-way round robin, otherwise fixed priority D over F.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input logic                clk,
    input logic                reset,
    mem_port_arbiter_if.master bus
);

    arbId_e               winner;
    arbId_e               head_id;
    logic                 have_winner;
    logic                 accept;
    logic                 can_issue;
    logic                 pop;
    logic                 unmatched;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ARB_CNT_W-1:0] fifo_count;
    logic                 err_q;

    assign pop       = bus.mem_rvalid_i && !fifo_empty;
    assign unmatched = bus.mem_rvalid_i && (fifo_count == '0);
    // A response in the same cycle frees a slot, so a full FIFO may still issue.
    assign can_issue = !fifo_full || pop;

`ifdef ARB_ROUND_ROBIN_EN
    // Holds the requester that wins the next conflict.
    arbId_e rr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= ARB_DATA;
        end else if (accept) begin
            rr_ptr <= arb_other(winner);
        end
    end
`endif

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        winner      = ARB_DATA;
        have_winner = 1'b0;
        if (!reset && can_issue && (bus.f_req_i || bus.d_req_i)) begin
            have_winner = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            if (bus.f_req_i && bus.d_req_i) begin
                winner = rr_ptr;
            end else begin
                winner = bus.d_req_i ? ARB_DATA : ARB_FETCH;
            end
`else
            winner = bus.d_req_i ? ARB_DATA : ARB_FETCH;
`endif
        end
    end

    assign accept = have_winner && bus.mem_gnt_i;

    assign bus.mem_req_o   = have_winner;
    assign bus.mem_we_o    = (winner == ARB_DATA) ? bus.d_we_i : 4'b0000;
    assign bus.mem_addr_o  = (winner == ARB_DATA) ? bus.d_addr_i : bus.f_addr_i;
    assign bus.mem_wdata_o = (winner == ARB_DATA) ? bus.d_wdata_i : 32'h0;

    assign bus.f_gnt_o = accept && (winner == ARB_FETCH);
    assign bus.d_gnt_o = accept && (winner == ARB_DATA);

    assign bus.f_rvalid_o = !reset && pop && (head_id == ARB_FETCH);
    assign bus.d_rvalid_o = !reset && pop && (head_id == ARB_DATA);
    assign bus.f_rdata_o  = bus.mem_rdata_i;
    assign bus.d_rdata_o  = bus.mem_rdata_i;

    // Sticky: a response with nothing outstanding means memory and arbiter disagree.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (unmatched) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_o = err_q;

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept),
        .pop     (pop),
        .id_in   (winner),
        .id_head (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MAX_OUTSTANDING = 2); honours ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    // {mem_req, f_gnt, d_gnt, f_rvalid, d_rvalid}
    function automatic logic [4:0] flags();
        return {bus.mem_req_o, bus.f_gnt_o, bus.d_gnt_o, bus.f_rvalid_o, bus.d_rvalid_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.f_req_i      = 1'b0;
        bus.f_addr_i     = 32'h0;
        bus.d_req_i      = 1'b0;
        bus.d_we_i       = 4'b0000;
        bus.d_addr_i     = 32'h0;
        bus.d_wdata_i    = 32'h0;
        bus.mem_gnt_i    = 1'b1;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
    endtask

    task automatic test_reset();
        idle();
        reset            = 1'b1;
        bus.f_req_i      = 1'b1;
        bus.d_req_i      = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        #1;
        checks++;
        if (flags() !== 5'b00000) begin
            errors++; $display("FAIL reset_flags_pre_edge: got %b expected %b", flags(), 5'b00000);
        end
        tick();
        checks++;
        if (flags() !== 5'b00000) begin
            errors++; $display("FAIL reset_flags: got %b expected %b", flags(), 5'b00000);
        end
        checks++;
        if (bus.err_o !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b expected 0", bus.err_o);
        end
        reset = 1'b0;
        idle();
        #1;
        checks++;
        if (flags() !== 5'b00000) begin
            errors++; $display("FAIL reset_idle_flags: got %b expected %b", flags(), 5'b00000);
        end
        tick();
    endtask

    task automatic test_single_read();
        idle();
        bus.f_req_i  = 1'b1;
        bus.f_addr_i = 32'h0000_0100;
        #1;
        checks++;
        if (flags() !== 5'b11000) begin
            errors++; $display("FAIL single_grant: got %b expected %b", flags(), 5'b11000);
        end
        checks++;
        if (bus.mem_addr_o !== 32'h0000_0100 || bus.mem_we_o !== 4'b0000) begin
            errors++; $display("FAIL single_fields: got addr %h we %b expected addr 00000100 we 0000",
                               bus.mem_addr_o, bus.mem_we_o);
        end
        tick();
        bus.f_req_i = 1'b0;
        #1;
        checks++;
        if (flags() !== 5'b00000) begin
            errors++; $display("FAIL single_wait: got %b expected %b", flags(), 5'b00000);
        end
        tick();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (flags() !== 5'b00010) begin
            errors++; $display("FAIL single_rvalid: got %b expected %b", flags(), 5'b00010);
        end
        checks++;
        if (bus.f_rdata_o !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL single_rdata: got %h expected deadbeef", bus.f_rdata_o);
        end
        tick();
        idle();
        #1;
        checks++;
        if (flags() !== 5'b00000) begin
            errors++; $display("FAIL single_after: got %b expected %b", flags(), 5'b00000);
        end
        tick();
    endtask

    task automatic test_conflict();
        logic [4:0] exp_flags;
        idle();
        bus.f_req_i   = 1'b1;
        bus.f_addr_i  = 32'h0000_0200;
        bus.d_req_i   = 1'b1;
        bus.d_we_i    = 4'b1111;
        bus.d_addr_i  = 32'h0000_0300;
        bus.d_wdata_i = 32'hCAFE_0001;
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 4; i++) begin
            bus.mem_rvalid_i = (i > 0);
            #1;
            exp_flags = {1'b1, (i % 2) == 1, (i % 2) == 0, i == 2, (i == 1) || (i == 3)};
            checks++;
            if (flags() !== exp_flags) begin
                errors++; $display("FAIL rr_cycle%0d: got %b expected %b", i, flags(), exp_flags);
            end
            tick();
        end
        bus.f_req_i = 1'b0;
        bus.d_req_i = 1'b0;
        #1;
        checks++;
        if (flags() !== 5'b00010) begin
            errors++; $display("FAIL rr_drain: got %b expected %b", flags(), 5'b00010);
        end
        tick();
`else
        #1;
        exp_flags = 5'b10100;
        checks++;
        if (flags() !== exp_flags) begin
            errors++; $display("FAIL prio_d_first: got %b expected %b", flags(), exp_flags);
        end
        checks++;
        if (bus.mem_we_o !== 4'b1111 || bus.mem_addr_o !== 32'h0000_0300 || bus.mem_wdata_o !== 32'hCAFE_0001) begin
            errors++; $display("FAIL prio_d_fields: got we %b addr %h wdata %h expected we 1111 addr 00000300 wdata cafe0001",
                               bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
        end
        tick();
        bus.d_req_i      = 1'b0;
        bus.d_we_i       = 4'b0000;
        bus.mem_rvalid_i = 1'b1;
        #1;
        checks++;
        if (flags() !== 5'b11001) begin
            errors++; $display("FAIL prio_f_next: got %b expected %b", flags(), 5'b11001);
        end
        checks++;
        if (bus.mem_addr_o !== 32'h0000_0200 || bus.mem_we_o !== 4'b0000) begin
            errors++; $display("FAIL prio_f_fields: got addr %h we %b expected addr 00000200 we 0000",
                               bus.mem_addr_o, bus.mem_we_o);
        end
        tick();
        bus.f_req_i = 1'b0;
        #1;
        checks++;
        if (flags() !== 5'b00010) begin
            errors++; $display("FAIL prio_drain: got %b expected %b", flags(), 5'b00010);
        end
        tick();
`endif
        idle();
    endtask

    task automatic test_full_fifo();
        idle();
        bus.d_req_i  = 1'b1;
        bus.d_addr_i = 32'h10;
        #1;
        checks++;
        if (flags() !== 5'b10100) begin
            errors++; $display("FAIL full_accept1: got %b expected %b", flags(), 5'b10100);
        end
        tick();
        bus.d_addr_i = 32'h14;
        #1;
        checks++;
        if (flags() !== 5'b10100) begin
            errors++; $display("FAIL full_accept2: got %b expected %b", flags(), 5'b10100);
        end
        tick();
        bus.d_addr_i = 32'h18;
        #1;
        checks++;
        if (flags() !== 5'b00000) begin
            errors++; $display("FAIL full_blocked: got %b expected %b", flags(), 5'b00000);
        end
        tick();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h11;
        #1;
        checks++;
        if (flags() !== 5'b10101 || bus.d_rdata_o !== 32'h11) begin
            errors++; $display("FAIL full_pop_accept: got flags %b rdata %h expected flags 10101 rdata 00000011",
                               flags(), bus.d_rdata_o);
        end
        tick();
        bus.d_addr_i     = 32'h1C;
        bus.mem_rvalid_i = 1'b0;
        #1;
        checks++;
        if (flags() !== 5'b00000) begin
            errors++; $display("FAIL full_still_full: got %b expected %b", flags(), 5'b00000);
        end
        tick();
        bus.mem_rvalid_i = 1'b1;
        #1;
        checks++;
        if (flags() !== 5'b10101) begin
            errors++; $display("FAIL full_pop_accept2: got %b expected %b", flags(), 5'b10101);
        end
        tick();
        bus.d_req_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (flags() !== 5'b00001) begin
                errors++; $display("FAIL full_drain%0d: got %b expected %b", i, flags(), 5'b00001);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_ordering();
        idle();
        bus.d_req_i  = 1'b1;
        bus.d_addr_i = 32'h40;
        #1;
        checks++;
        if (flags() !== 5'b10100) begin
            errors++; $display("FAIL order_d1: got %b expected %b", flags(), 5'b10100);
        end
        tick();
        bus.d_req_i  = 1'b0;
        bus.f_req_i  = 1'b1;
        bus.f_addr_i = 32'h44;
        #1;
        checks++;
        if (flags() !== 5'b11000) begin
            errors++; $display("FAIL order_f: got %b expected %b", flags(), 5'b11000);
        end
        tick();
        bus.f_req_i      = 1'b0;
        bus.d_req_i      = 1'b1;
        bus.d_addr_i     = 32'h48;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h1;
        #1;
        checks++;
        if (flags() !== 5'b10101 || bus.d_rdata_o !== 32'h1) begin
            errors++; $display("FAIL order_resp1: got flags %b rdata %h expected flags 10101 rdata 00000001",
                               flags(), bus.d_rdata_o);
        end
        tick();
        bus.d_req_i     = 1'b0;
        bus.mem_rdata_i = 32'h2;
        #1;
        checks++;
        if (flags() !== 5'b00010 || bus.f_rdata_o !== 32'h2) begin
            errors++; $display("FAIL order_resp2: got flags %b rdata %h expected flags 00010 rdata 00000002",
                               flags(), bus.f_rdata_o);
        end
        tick();
        bus.mem_rdata_i = 32'h3;
        #1;
        checks++;
        if (flags() !== 5'b00001 || bus.d_rdata_o !== 32'h3) begin
            errors++; $display("FAIL order_resp3: got flags %b rdata %h expected flags 00001 rdata 00000003",
                               flags(), bus.d_rdata_o);
        end
        tick();
        idle();
    endtask

    task automatic test_backpressure();
        idle();
        bus.d_req_i   = 1'b1;
        bus.d_addr_i  = 32'h500;
        bus.d_we_i    = 4'b0011;
        bus.d_wdata_i = 32'h1234_5678;
        bus.mem_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (flags() !== 5'b10000 || bus.mem_addr_o !== 32'h500) begin
                errors++; $display("FAIL bp_stall%0d: got flags %b addr %h expected flags 10000 addr 00000500",
                                   i, flags(), bus.mem_addr_o);
            end
            tick();
        end
        bus.mem_gnt_i = 1'b1;
        #1;
        checks++;
        if (flags() !== 5'b10100 || bus.mem_we_o !== 4'b0011) begin
            errors++; $display("FAIL bp_grant: got flags %b we %b expected flags 10100 we 0011",
                               flags(), bus.mem_we_o);
        end
        tick();
        bus.d_req_i      = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        #1;
        checks++;
        if (flags() !== 5'b00001) begin
            errors++; $display("FAIL bp_resp: got %b expected %b", flags(), 5'b00001);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.err_o !== 1'b0) begin
            errors++; $display("FAIL bp_no_err: got %b expected 0", bus.err_o);
        end
    endtask

    task automatic test_err_reset();
        idle();
        bus.d_req_i  = 1'b1;
        bus.d_addr_i = 32'h600;
        #1;
        checks++;
        if (flags() !== 5'b10100) begin
            errors++; $display("FAIL err_accept: got %b expected %b", flags(), 5'b10100);
        end
        tick();
        bus.d_req_i = 1'b0;
        reset       = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.err_o !== 1'b0) begin
            errors++; $display("FAIL err_after_reset: got %b expected 0", bus.err_o);
        end
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h77;
        #1;
        checks++;
        if (flags() !== 5'b00000) begin
            errors++; $display("FAIL err_late_resp: got %b expected %b", flags(), 5'b00000);
        end
        tick();
        bus.mem_rvalid_i = 1'b0;
        #1;
        checks++;
        if (bus.err_o !== 1'b1) begin
            errors++; $display("FAIL err_set: got %b expected 1", bus.err_o);
        end
        bus.f_req_i  = 1'b1;
        bus.f_addr_i = 32'h700;
        tick();
        bus.f_req_i      = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        #1;
        checks++;
        if (flags() !== 5'b00010) begin
            errors++; $display("FAIL err_normal_resp: got %b expected %b", flags(), 5'b00010);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.err_o !== 1'b1) begin
            errors++; $display("FAIL err_sticky: got %b expected 1", bus.err_o);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.err_o !== 1'b0) begin
            errors++; $display("FAIL err_cleared: got %b expected 0", bus.err_o);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_conflict();
        test_full_fifo();
        test_ordering();
        test_backpressure();
        test_err_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
